// File: rtl/display_scan.sv
// display_scan: time-multiplexed scanner for a bank of seven-segment digits.
// A prescaler divides clk into digit slots; each slot lights one digit (active-low
// anode) and drives its hex pattern and decimal point (active-low cathodes).
// Optional feature: define DISPLAY_SCAN_LZB_EN to blank leading zero digits
// (digit 0 is never blanked). Without the macro every digit is shown.

module display_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_o,
  output logic                          tick_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [6:0]            SEG_OFF  = 7'b1111111;

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

`ifdef DISPLAY_SCAN_LZB_EN
  // True when digit idx sits above the most significant nonzero nibble.
  // Digit 0 is never blanked because the top index starts at 0.
  function automatic logic is_leading_zero(input logic [4*NUM_DIGITS-1:0] digits,
                                           input logic [IDX_W-1:0]        idx);
    logic [IDX_W-1:0] top;
    top = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (digits[4*k +: 4] != 4'h0) begin
        top = IDX_W'(k);
      end else begin
        top = top;
      end
    end
    return (idx > top);
  endfunction
`endif

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  tick_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  logic [CNT_W-1:0]      cnt_next_s;
  logic [IDX_W-1:0]      idx_next_s;
  logic                  tick_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;
  logic [6:0]            seg_next_s;
  logic                  dp_next_s;
  logic [3:0]            nibble_s;
  logic                  dead_s;
  logic                  digit_blank_s;

  // Guard window at the start of each slot; absent entirely when DEAD_CYCLES is 0.
  generate
    if (DEAD_CYCLES > 0) begin : g_dead
      assign dead_s = (cnt_r < CNT_W'(DEAD_CYCLES));
    end else begin : g_no_dead
      assign dead_s = 1'b0;
    end
  endgenerate

`ifdef DISPLAY_SCAN_LZB_EN
  // Leading-zero blanking decision for the digit currently selected.
  always_comb begin
    digit_blank_s = is_leading_zero(digits_i, idx_r);
  end
`else
  // Without blanking every digit is displayed.
  always_comb begin
    digit_blank_s = 1'b0;
  end
`endif

  // Prescaler / digit index next state; everything freezes while en is low.
  always_comb begin
    cnt_next_s  = cnt_r;
    idx_next_s  = idx_r;
    tick_next_s = 1'b0;
    if (en) begin
      if (cnt_r >= CNT_LAST) begin
        cnt_next_s  = '0;
        tick_next_s = 1'b1;
        if (idx_r >= IDX_LAST) begin
          idx_next_s = '0;
        end else begin
          idx_next_s = idx_r + IDX_W'(1);
        end
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
      idx_next_s = idx_r;
    end
  end

  // Display drive for the currently selected digit, registered one cycle later.
  always_comb begin
    nibble_s   = digits_i[4*idx_r +: 4];
    seg_next_s = hex_to_seg(nibble_s);
    an_next_s  = AN_OFF;
    dp_next_s  = 1'b1;
    if (!en || dead_s || digit_blank_s) begin
      an_next_s = AN_OFF;
    end else begin
      an_next_s = ~(AN_ONE << idx_r);
    end
    if (digit_blank_s) begin
      dp_next_s = 1'b1;
    end else begin
      dp_next_s = ~dp_i[idx_r];
    end
  end

  // Scan state registers with synchronous reset that overrides en.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= '0;
      idx_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      idx_r  <= idx_next_s;
      tick_r <= tick_next_s;
    end
  end

  // Registered display outputs; reset blanks anodes and cathodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an_o   = an_r;
  assign seg_o  = seg_r;
  assign dp_o   = dp_r;
  assign idx_o  = idx_r;
  assign tick_o = tick_r;

endmodule

// File: tb/tb_display_scan.sv
// Randomized scoreboard bench for display_scan (NUM_DIGITS=8, PRESCALE=4).
// Two instances run side by side: one without dead time, one with DEAD_CYCLES=1.
// The reference model tracks the number of enabled cycles since reset and
// derives slot position, digit index and expected outputs arithmetically.

module tb_display_scan;

  localparam int N = 8;
  localparam int P = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [7:0] an0;
    logic [7:0] an1;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] digits;
  logic [7:0]  dp;

  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dpo0, dpo1;
  logic [2:0] idx0, idx1;
  logic       tick0, tick1;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   act    = 0;   // enabled cycles since last reset

  always #5 clk = ~clk;

  display_scan #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .digits_i(digits), .dp_i(dp),
    .an_o(an0), .seg_o(seg0), .dp_o(dpo0), .idx_o(idx0), .tick_o(tick0)
  );

  display_scan #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .digits_i(digits), .dp_i(dp),
    .an_o(an1), .seg_o(seg1), .dp_o(dpo1), .idx_o(idx1), .tick_o(tick1)
  );

  function automatic int top_nonzero(input logic [31:0] d);
    int t;
    t = 0;
    for (int k = 0; k < N; k++) begin
      if (((d >> (4 * k)) & 32'hF) != 32'h0) t = k;
    end
    return t;
  endfunction

  function automatic logic blanked(input logic [31:0] d, input int i);
`ifdef DISPLAY_SCAN_LZB_EN
    return (i > top_nonzero(d));
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle of inputs, queue the response expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [31:0] d, input logic [7:0] p);
    exp_t       x;
    int         cnt;
    int         cur;
    logic       b;
    logic [3:0] nib;
    logic [7:0] onehot_low;
    reset  = r;
    en     = e;
    digits = d;
    dp     = p;
    if (r) begin
      x.an0  = 8'hFF;
      x.an1  = 8'hFF;
      x.seg  = 7'b1111111;
      x.dp   = 1'b1;
      x.idx  = 3'd0;
      x.tick = 1'b0;
      act    = 0;
    end else begin
      cnt        = act % P;
      cur        = (act / P) % N;
      b          = blanked(d, cur);
      nib        = d[4*cur +: 4];
      onehot_low = ~(8'(1) << cur);
      x.tick     = e && (cnt == P - 1);
      x.seg      = SEG_TAB[nib];
      x.dp       = b ? 1'b1 : ~p[cur];
      x.an0      = (!e || b) ? 8'hFF : onehot_low;
      x.an1      = (!e || b || cnt < 1) ? 8'hFF : onehot_low;
      if (e) act++;
      x.idx      = 3'((act / P) % N);
    end
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Run enabled until the model reaches the given digit and prescaler value.
  task automatic run_to(input int want_idx, input int want_cnt);
    int n;
    n = 0;
    while (!(((act / P) % N) == want_idx && (act % P) == want_cnt) && n < 64) begin
      step(1'b0, 1'b1, $urandom, 8'($urandom));
      n++;
    end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL run_to: got no match expected idx %0d cnt %0d", want_idx, want_cnt);
    end
  endtask

  // Monitor: compare both DUTs against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("an0",   32'(an0),   32'(x.an0));
        chk("an1",   32'(an1),   32'(x.an1));
        chk("seg0",  32'(seg0),  32'(x.seg));
        chk("seg1",  32'(seg1),  32'(x.seg));
        chk("dp0",   32'(dpo0),  32'(x.dp));
        chk("dp1",   32'(dpo1),  32'(x.dp));
        chk("idx0",  32'(idx0),  32'(x.idx));
        chk("idx1",  32'(idx1),  32'(x.idx));
        chk("tick0", 32'(tick0), 32'(x.tick));
        chk("tick1", 32'(tick1), 32'(x.tick));
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic r;
    logic e;
    logic [31:0] d;
    reset  = 1'b1;
    en     = 1'b0;
    digits = 32'h0;
    dp     = 8'h0;
    repeat (3) step(1'b1, 1'b0, 32'h0, 8'h0);
    repeat (40) step(1'b0, 1'b1, 32'h0123ABCF, 8'h01);
    repeat (60) step(1'b0, 1'b1, $urandom, 8'($urandom));
    // Freeze mid-slot at digit 5, prescaler 2.
    run_to(5, 2);
    repeat (10) step(1'b0, 1'b0, $urandom, 8'($urandom));
    repeat (8) step(1'b0, 1'b1, $urandom, 8'($urandom));
    // Reset mid-slot at digit 6, prescaler 3, with en held high.
    run_to(6, 3);
    step(1'b1, 1'b1, 32'h0123ABCF, 8'h01);
    repeat (12) step(1'b0, 1'b1, 32'h0123ABCF, 8'h01);
    // Leading-zero patterns.
    repeat (40) step(1'b0, 1'b1, 32'h00000340, 8'hFF);
    repeat (40) step(1'b0, 1'b1, 32'h00000000, 8'hFF);
    // Random mix of enable, reset and sparse digit values.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 5) != 0);
      d = $urandom >> (4 * $urandom_range(0, 8));
      step(r, e, d, 8'($urandom));
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
